// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC + RAM read, word presented by valid/ready; a transfer per 3 cycles when unstalled.
// Yields the RAM port while Mem_busy; holds the word until Instr_ready; branch redirects/flushes.
module instruction_fetch_unit #(
  parameter int                 ADDR_W     = 16,
  parameter int                 DATA_W     = 32,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter logic [DATA_W-1:0]  HALT_WORD  = '1,
  parameter int                 RAM_LAT    = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Mem_busy,
  input  logic              Branch_valid,
  input  logic [ADDR_W-1:0] Branch_target,
  output logic              Ram_Enable,
  output logic              Ram_RW,
  output logic [ADDR_W-1:0] Ram_Address,
  input  logic [DATA_W-1:0] Ram_Data,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] Instr_PC,
  output logic              Instr_valid,
  input  logic              Instr_ready,
  output logic              Halted
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] HALTED = 3'd4;

  localparam int CNT_W = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              ram_en_q, ram_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flush_q, flush_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    ram_en_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    halted_d      = halted_q;
    cnt_d         = cnt_q;
    flush_d       = flush_q;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = REQ;
          pc_d    = START_ADDR;
        end
      end
      REQ: begin
        if (!Mem_busy) begin
          ram_en_d   = 1'b1;
          ram_addr_d = pc_q;
          cnt_d      = CNT_W'(RAM_LAT);
          state_d    = WAIT;
          // A redirect in the issuing cycle still lets the read go out; its data is dropped.
          if (Branch_valid) flush_d = 1'b1;
        end
        if (Branch_valid) pc_d = Branch_target;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (Branch_valid) begin
          pc_d    = Branch_target;
          flush_d = 1'b1;
        end
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d = '0;
          if (flush_q || Branch_valid) begin
            flush_d = 1'b0;
            state_d = REQ;
          end else if (Ram_Data == HALT_WORD) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            instr_d       = Ram_Data;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 1'b1;
            state_d       = HOLD;
          end
        end
      end
      HOLD: begin
        // Redirect wins over a same-cycle handshake: the held word is discarded.
        if (Branch_valid) begin
          pc_d          = Branch_target;
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end else if (Instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end
      end
      HALTED: begin
        if (Start) begin
          halted_d = 1'b0;
          pc_d     = START_ADDR;
          state_d  = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      pc_q          <= START_ADDR;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_addr_q    <= '0;
      halted_q      <= 1'b0;
      cnt_q         <= '0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      ram_en_q      <= ram_en_d;
      ram_addr_q    <= ram_addr_d;
      halted_q      <= halted_d;
      cnt_q         <= cnt_d;
      flush_q       <= flush_d;
    end
  end

  assign Ram_Enable  = ram_en_q;
  assign Ram_RW      = 1'b1;
  assign Ram_Address = ram_addr_q;
  assign Instr       = instr_q;
  assign Instr_PC    = instr_pc_q;
  assign Instr_valid = instr_valid_q;
  assign Halted      = halted_q;

endmodule
